// File: rtl/pif_i2c_master.sv
// pif_i2c_master: byte-level I2C initiator issuing single-register write/read transactions.
// Bit timing is a quarter-period divider on xclk (SCL period = 4*CLK_DIV); one command in flight at a time.
// Optional macro I2C_STRETCH_EN: honour slave clock stretching (wait for scl_in high after each SCL release).
module pif_i2c_master #(
  parameter int CLK_DIV  = 30,
  parameter int DIV_BITS = 10
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_sub,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, SUB, WDATA, RSTART, ADDR_R, RDATA, MACK, STOP, DONE
  } state_e;

  localparam logic [DIV_BITS-1:0] DIV_RELOAD = DIV_BITS'(CLK_DIV - 1);
  localparam logic [DIV_BITS-1:0] DIV_ONE    = DIV_BITS'(1);

  state_e              state_q;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic                tick;
  logic                scl_wait;
  logic [1:0]          qtr_q;
  logic [3:0]          bit_q;
  logic [7:0]          shift_q;
  logic [7:0]          rx_q;
  logic                ack_q;
  logic                nack_q;
  logic                rw_q;
  logic [6:0]          addr_q;
  logic [7:0]          sub_q;
  logic [7:0]          wdata_q;
  logic                cmd_ready_q, busy_q, rsp_valid_q, rsp_nack_q;
  logic [7:0]          rsp_rdata_q;
  logic                scl_oe_q, sda_oe_q;

`ifdef I2C_STRETCH_EN
  // Q2 is the SCL-high quarter: do not start timing it until the line has really risen.
  assign scl_wait = (qtr_q == 2'd2) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign scl_wait      = 1'b0;
`endif

  // Quarter-period divider: parked at reload outside a transaction, ticks when it reaches zero.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (state_q == IDLE || state_q == DONE) begin
      div_d = DIV_RELOAD;
    end else if (!scl_wait) begin
      if (div_q == '0) begin
        tick  = 1'b1;
        div_d = DIV_RELOAD;
      end else begin
        div_d = div_q - DIV_ONE;
      end
    end
  end

  // Divider register.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) div_q <= DIV_RELOAD;
    else          div_q <= div_d;
  end

  // Transaction FSM with registered bus drivers and response outputs.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      shift_q     <= 8'h00;
      rx_q        <= 8'h00;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 7'h00;
      sub_q       <= 8'h00;
      wdata_q     <= 8'h00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= 8'h00;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            rw_q        <= cmd_rw;
            addr_q      <= cmd_addr;
            sub_q       <= cmd_sub;
            wdata_q     <= cmd_wdata;
            nack_q      <= 1'b0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end

        DONE: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (state_q)
              // (Repeated) start: release SDA, release SCL, drop SDA while SCL high, pull SCL.
              START, RSTART: begin
                case (qtr_q)
                  2'd0: sda_oe_q <= 1'b0;
                  2'd1: scl_oe_q <= 1'b0;
                  2'd2: sda_oe_q <= 1'b1;
                  default: begin
                    scl_oe_q <= 1'b1;
                    bit_q    <= 4'd0;
                    shift_q  <= {addr_q, (state_q == RSTART)};
                    state_q  <= (state_q == START) ? ADDR_W : ADDR_R;
                  end
                endcase
              end

              // Transmit 8 bits MSB first, then release SDA for the slave ACK slot.
              ADDR_W, SUB, WDATA, ADDR_R: begin
                case (qtr_q)
                  2'd0: sda_oe_q <= (bit_q == 4'd8) ? 1'b0 : ~shift_q[7];
                  2'd1: scl_oe_q <= 1'b0;
                  2'd2: if (bit_q == 4'd8) ack_q <= sda_in;
                  default: begin
                    scl_oe_q <= 1'b1;
                    if (bit_q != 4'd8) begin
                      bit_q   <= bit_q + 4'd1;
                      shift_q <= {shift_q[6:0], 1'b0};
                    end else begin
                      bit_q <= 4'd0;
                      if (ack_q) begin
                        // No ACK: abandon the rest of the transaction.
                        nack_q  <= 1'b1;
                        state_q <= STOP;
                      end else begin
                        case (state_q)
                          ADDR_W: begin
                            shift_q <= sub_q;
                            state_q <= SUB;
                          end
                          SUB: begin
                            shift_q <= wdata_q;
                            state_q <= rw_q ? RSTART : WDATA;
                          end
                          ADDR_R:  state_q <= RDATA;
                          default: state_q <= STOP;
                        endcase
                      end
                    end
                  end
                endcase
              end

              // Receive 8 bits MSB first with SDA released.
              RDATA: begin
                case (qtr_q)
                  2'd0: sda_oe_q <= 1'b0;
                  2'd1: scl_oe_q <= 1'b0;
                  2'd2: rx_q     <= {rx_q[6:0], sda_in};
                  default: begin
                    scl_oe_q <= 1'b1;
                    if (bit_q == 4'd7) begin
                      bit_q   <= 4'd0;
                      state_q <= MACK;
                    end else begin
                      bit_q <= bit_q + 4'd1;
                    end
                  end
                endcase
              end

              // Master NACK (SDA left released) closes the single-byte read.
              MACK: begin
                case (qtr_q)
                  2'd0: sda_oe_q <= 1'b0;
                  2'd1: scl_oe_q <= 1'b0;
                  2'd2: ;
                  default: begin
                    scl_oe_q <= 1'b1;
                    state_q  <= STOP;
                  end
                endcase
              end

              // Stop: SDA low under SCL low, release SCL, then release SDA; then report.
              STOP: begin
                case (qtr_q)
                  2'd0: sda_oe_q <= 1'b1;
                  2'd1: scl_oe_q <= 1'b0;
                  2'd2: sda_oe_q <= 1'b0;
                  default: begin
                    rsp_valid_q <= 1'b1;
                    rsp_nack_q  <= nack_q;
                    if (rw_q && !nack_q) rsp_rdata_q <= rx_q;
                    state_q <= DONE;
                  end
                endcase
              end

              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_pif_i2c_master.sv
// tb_pif_i2c_master: drives write/read/NACK/reset/back-to-back commands into pif_i2c_master
// against a behavioural open-drain I2C slave; bus tokens and responses go through scoreboards.
module tb_pif_i2c_master;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h41;
  localparam int TOK_S = 'h100, TOK_P = 'h200, TOK_MACK = 'h300;
  localparam int PH_IDLE = 0, PH_ADDR = 1, PH_SUB = 2, PH_WR = 3, PH_RD = 4;

  logic xclk = 1'b0;
  logic sys_rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_sub = '0, cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
  logic [7:0] rsp_rdata;
  logic sl_scl = 1'b0, sl_sda = 1'b0;
  logic scl_w, sda_w;

  assign scl_w = ~scl_oe & ~sl_scl;
  assign sda_w = ~sda_oe & ~sl_sda;

  always #5 xclk = ~xclk;

  pif_i2c_master #(.CLK_DIV(CLK_DIV), .DIV_BITS(10)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_sub(cmd_sub), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_w), .sda_in(sda_w)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboards and reference model
  int         exp_bus[$];
  logic [8:0] exp_rsp[$];
  logic [7:0] model_mem[256];
  logic [7:0] slv_mem[256];
  logic [7:0] last_rdata = 8'h00;

  task automatic push_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] sub,
                          input logic [7:0] wdata);
    exp_bus.push_back(TOK_S);
    exp_bus.push_back(int'({addr, 1'b0}));
    if (addr != SLV_ADDR) begin
      exp_bus.push_back(TOK_P);
      exp_rsp.push_back({1'b1, last_rdata});
    end else if (!rw) begin
      exp_bus.push_back(int'(sub));
      exp_bus.push_back(int'(wdata));
      exp_bus.push_back(TOK_P);
      model_mem[sub] = wdata;
      exp_rsp.push_back({1'b0, last_rdata});
    end else begin
      exp_bus.push_back(int'(sub));
      exp_bus.push_back(TOK_S);
      exp_bus.push_back(int'({addr, 1'b1}));
      exp_bus.push_back(TOK_MACK | 1);
      exp_bus.push_back(TOK_P);
      last_rdata = model_mem[sub];
      exp_rsp.push_back({1'b0, last_rdata});
    end
  endtask

  task automatic log_bus(input int tok);
    if (exp_bus.size() == 0) check("bus_unexpected", tok, 32'hFFFF);
    else check("bus_token", tok, exp_bus.pop_front());
  endtask

  // Slave model, bus timing monitor and response checker share one block to avoid ordering races.
  logic p_scl = 1'b1, p_sda = 1'b1, got_rise = 1'b0, acked = 1'b0, rdmode = 1'b0;
  int   phase = PH_IDLE, bitn = 0, str_cnt = 0, cyc = 0, start_cyc = 0, stop_cyc = 0, hi_cnt = 0;
  logic have_stop = 1'b0, hi_ok = 1'b0, stretch_req = 1'b0, lat_chk = 1'b0, mon_en = 1'b0;
  logic [7:0] sh = '0, rd_sh = '0, sub_ptr = '0;

  always @(posedge xclk) begin
    cyc++;
    if (str_cnt > 0) begin
      str_cnt--;
      if (str_cnt == 0) sl_scl <= 1'b0;
    end
    if (p_scl && scl_w && p_sda && !sda_w) begin
      log_bus(TOK_S);
      if (have_stop) check("bus_free_ge_2q", int'((cyc - stop_cyc) >= 2 * CLK_DIV), 1);
      have_stop = 1'b0;
      bitn = 0; phase = PH_ADDR; got_rise = 1'b0; start_cyc = cyc;
      sl_sda <= 1'b0;
    end else if (p_scl && scl_w && !p_sda && sda_w) begin
      log_bus(TOK_P);
      phase = PH_IDLE; stop_cyc = cyc; have_stop = 1'b1;
    end else if (!p_scl && scl_w) begin
      got_rise = 1'b1;
      if (bitn < 8) sh = {sh[6:0], sda_w};
      else if (phase == PH_RD) log_bus(TOK_MACK | int'(sda_w));
    end else if (p_scl && !scl_w && got_rise && phase != PH_IDLE) begin
      got_rise = 1'b0;
      if (bitn < 8) begin
        bitn++;
        if (bitn < 8) begin
          if (phase == PH_RD) begin
            rd_sh = {rd_sh[6:0], 1'b0};
            sl_sda <= ~rd_sh[7];
          end
        end else begin
          case (phase)
            PH_ADDR: begin
              log_bus(int'(sh));
              acked = (sh[7:1] == SLV_ADDR);
              rdmode = sh[0];
              sl_sda <= acked;
            end
            PH_SUB: begin log_bus(int'(sh)); sub_ptr = sh; sl_sda <= 1'b1; end
            PH_WR:  begin log_bus(int'(sh)); slv_mem[sub_ptr] = sh; sl_sda <= 1'b1; end
            default: sl_sda <= 1'b0;
          endcase
        end
      end else begin
        bitn = 0;
        sl_sda <= 1'b0;
        case (phase)
          PH_ADDR: begin
            if (!acked) phase = PH_IDLE;
            else if (rdmode) begin
              phase = PH_RD;
              rd_sh = slv_mem[sub_ptr];
              sl_sda <= ~rd_sh[7];
            end else phase = PH_SUB;
          end
          PH_SUB: begin
            phase = PH_WR;
            if (stretch_req) begin
              stretch_req = 1'b0;
              sl_scl <= 1'b1;
              str_cnt = 50;
            end
          end
          PH_WR:   phase = PH_WR;
          default: phase = PH_IDLE;
        endcase
      end
    end
    // SCL high phases started during a transaction must last exactly two quarters.
    if (!busy) hi_ok = 1'b0;
    if (scl_w) begin
      if (!p_scl) begin hi_cnt = 0; hi_ok = busy; end
      hi_cnt++;
    end else if (p_scl && hi_ok) begin
      check("scl_high_width", hi_cnt, 2 * CLK_DIV);
      hi_ok = 1'b0;
    end
    if (mon_en) check("ready_vs_busy", cmd_ready, !busy);
    if (rsp_valid) begin
      check("rsp_busy_inclusive", busy, 1);
      if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_nack_rdata", {rsp_nack, rsp_rdata}, exp_rsp.pop_front());
      if (lat_chk) check("start_to_rsp_cycles", cyc - start_cyc, 113 * CLK_DIV);
      lat_chk = 1'b0;
    end
    p_scl = scl_w;
    p_sda = sda_w;
  end

  // Called at a negedge; leaves at the negedge after acceptance.
  task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] sub,
                       input logic [7:0] wdata, input logic keep_valid);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_sub = sub; cmd_wdata = wdata;
    for (int i = 0; i < 5000 && !cmd_ready; i++) @(negedge xclk);
    if (!cmd_ready) check("accept_timeout", 0, 1);
    else push_cmd(rw, addr, sub, wdata);
    @(negedge xclk);
    check("ready_low_after_accept", cmd_ready, 0);
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_sub = 8'hEE; cmd_wdata = 8'hEE; cmd_addr = 7'h7F;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && exp_rsp.size() > 0; i++) @(negedge xclk);
    check("rsp_pending", exp_rsp.size(), 0);
    check("bus_tokens_left", exp_bus.size(), 0);
    exp_rsp.delete();
    exp_bus.delete();
    repeat (3) @(negedge xclk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i ^ 8'h5C);
      slv_mem[i]   = 8'(i ^ 8'h5C);
    end
    repeat (3) @(negedge xclk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_nack", rsp_nack, 0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    sys_rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge xclk);

    // Write 0x02 to sub 0x03 of device 0x41, with exact start-to-response timing.
    lat_chk = 1'b1;
    issue(1'b0, 7'h41, 8'h03, 8'h02, 1'b0);
    wait_done();
    check("slave_mem_03", slv_mem[3], 8'h02);

    // Read back: slave now holds 0xA5 at sub 0x03.
    slv_mem[3] = 8'hA5; model_mem[3] = 8'hA5;
    issue(1'b1, 7'h41, 8'h03, 8'h00, 1'b0);
    wait_done();
    check("rdata_hold_after_read", rsp_rdata, 8'hA5);

    // Address NACK: no sub byte, rdata retained.
    issue(1'b0, 7'h22, 8'h10, 8'h77, 1'b0);
    wait_done();
    check("rdata_hold_after_nack", rsp_rdata, 8'hA5);
    check("nack_held", rsp_nack, 1);

    // Reset during bit 4 of SUB.
    issue(1'b0, 7'h41, 8'h07, 8'h5A, 1'b0);
    for (int i = 0; i < 5000 && !(phase == PH_SUB && bitn == 4); i++) @(negedge xclk);
    check("reached_sub_bit4", int'(phase == PH_SUB && bitn == 4), 1);
    sys_rst = 1'b0;
    #1;
    check("midrst_scl_oe", scl_oe, 0);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_busy", busy, 0);
    exp_bus.delete();
    exp_rsp.delete();
    last_rdata = 8'h00;
    repeat (2) @(negedge xclk);
    sys_rst = 1'b1;
    @(negedge xclk);
    check("midrst_ready_after", cmd_ready, 1);
    check("midrst_rdata_cleared", rsp_rdata, 8'h00);
    issue(1'b0, 7'h41, 8'h07, 8'h5A, 1'b0);
    wait_done();
    check("slave_mem_07", slv_mem[7], 8'h5A);

    // Back-to-back commands with cmd_valid held high.
    issue(1'b0, 7'h41, 8'h05, 8'h3C, 1'b1);
    issue(1'b0, 7'h41, 8'h06, 8'hC3, 1'b0);
    wait_done();
    issue(1'b1, 7'h41, 8'h06, 8'h00, 1'b0);
    wait_done();

`ifdef I2C_STRETCH_EN
    // Slave stretches SCL for 50 cycles after the SUB ACK slot.
    stretch_req = 1'b1;
    issue(1'b0, 7'h41, 8'h09, 8'h96, 1'b0);
    wait_done();
    check("stretch_consumed", stretch_req, 0);
    check("stretch_slave_mem_09", slv_mem[9], 8'h96);
    issue(1'b1, 7'h41, 8'h09, 8'h00, 1'b0);
    wait_done();
`else
    // Fixed timing: a second timed write of the same shape.
    lat_chk = 1'b1;
    issue(1'b0, 7'h41, 8'h09, 8'h96, 1'b0);
    wait_done();
    check("slave_mem_09", slv_mem[9], 8'h96);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
